// File: rtl/regcep_ctrl.sv
// Arbitrates a cepstral-coefficient register file between the MFCC writer and the matcher reader,
// tracking how many complete frames are stored and flagging out-of-range reads.
module regcep_ctrl #(
  parameter int NCOEF  = 26,
  parameter int NFRAME = 256,
  parameter int WBURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        wr_req,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [7:0]  rd_frame,
  input  logic [4:0]  rd_coef,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic [12:0] cep_addr,
  output logic [15:0] cep_wdata,
  output logic        cep_wren,
  input  logic [15:0] cep_rdata,
  output logic [8:0]  frame_count,
  output logic        frame_done,
  output logic        full
);

  localparam int SW = $clog2(WBURST + 1);
  localparam logic [4:0]    LAST_COEF  = 5'(NCOEF - 1);
  localparam logic [4:0]    NCOEF_5    = 5'(NCOEF);
  localparam logic [8:0]    LAST_FRAME = 9'(NFRAME - 1);
  localparam logic [SW-1:0] BURST_MAX  = SW'(WBURST);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FULL} state_t;

  state_t        state_q, state_d;
  logic [4:0]    coef_idx;
  logic [7:0]    frame_idx;
  logic [SW-1:0] wr_streak;
  logic          wr_elig, rd_elig, wr_grant, rd_grant, rd_oor;
  logic          last_coef;
  logic [12:0]   wr_addr, rd_addr;

  assign full      = (state_q == FULL);
  assign wr_ack    = wr_grant;
  assign rd_ack    = rd_grant;
  assign last_coef = (coef_idx == LAST_COEF);

  // Grant selection, register-file drive and next state; the writer yields once its streak hits WBURST
  always_comb begin
    wr_elig   = 1'b0;
    rd_elig   = 1'b0;
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    cep_addr  = '0;
    cep_wdata = '0;
    cep_wren  = 1'b0;
    state_d   = state_q;
    wr_addr   = 13'(frame_idx) * 13'(NCOEF) + 13'(coef_idx);
    rd_addr   = 13'(rd_frame) * 13'(NCOEF) + 13'(rd_coef);
    rd_oor    = (rd_coef >= NCOEF_5) || ({1'b0, rd_frame} >= frame_count);

    if (!reset && !clear) begin
      wr_elig  = wr_req && !full;
      rd_elig  = rd_req;
      wr_grant = wr_elig && !(rd_elig && wr_streak >= BURST_MAX);
      rd_grant = rd_elig && !wr_grant;
    end

    if (wr_grant) begin
      cep_addr  = wr_addr;
      cep_wdata = wr_data;
      cep_wren  = 1'b1;
    end else if (rd_grant) begin
      cep_addr = rd_oor ? 13'd0 : rd_addr;
    end

    if (clear)
      state_d = IDLE;
    else if (state_q == FULL)
      state_d = FULL;
    else if (wr_grant && last_coef && frame_count == LAST_FRAME)
      state_d = FULL;
    else if (wr_grant)
      state_d = WRITE;
    else if (rd_grant)
      state_d = READ;
    else
      state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      coef_idx    <= '0;
      frame_idx   <= '0;
      frame_count <= '0;
      wr_streak   <= '0;
      frame_done  <= 1'b0;
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      rd_data     <= '0;
    end else begin
      state_q    <= state_d;
      frame_done <= 1'b0;
      rd_valid   <= rd_grant;
      rd_err     <= rd_grant && rd_oor;
      if (rd_grant)
        rd_data <= rd_oor ? 16'd0 : cep_rdata;

      if (clear) begin
        coef_idx    <= '0;
        frame_idx   <= '0;
        frame_count <= '0;
        wr_streak   <= '0;
      end else begin
        if (wr_grant) begin
          if (last_coef) begin
            coef_idx    <= '0;
            frame_idx   <= frame_idx + 8'd1;
            frame_count <= frame_count + 9'd1;
            frame_done  <= 1'b1;
          end else begin
            coef_idx <= coef_idx + 5'd1;
          end
        end
        // Streak only counts writer wins while the reader is actually waiting
        if (rd_grant || !rd_req)
          wr_streak <= '0;
        else if (wr_grant)
          wr_streak <= wr_streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regcep_ctrl.sv
// Directed bench for regcep_ctrl with a behavioural register file hung on the cep_* port.
module tb_regcep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_frame = '0;
  logic [4:0]  rd_coef = '0;
  logic        rd_ack, rd_valid, rd_err;
  logic [15:0] rd_data;
  logic [12:0] cep_addr;
  logic [15:0] cep_wdata, cep_rdata;
  logic        cep_wren;
  logic [8:0]  frame_count;
  logic        frame_done, full;

  logic [15:0] mem [0:8191];
  int n_checks = 0;
  int n_pass   = 0;

  regcep_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_frame(rd_frame), .rd_coef(rd_coef),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .cep_addr(cep_addr), .cep_wdata(cep_wdata), .cep_wren(cep_wren), .cep_rdata(cep_rdata),
    .frame_count(frame_count), .frame_done(frame_done), .full(full)
  );

  always #5 clk = ~clk;

  assign cep_rdata = mem[cep_addr];
  always @(posedge clk) if (cep_wren) mem[cep_addr] <= cep_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Drives one cycle's inputs just after the falling edge so combinational outputs settle by #1
  task automatic applyStimulus(input logic w, input logic [15:0] wd, input logic r,
                               input logic [7:0] rf, input logic [4:0] rc, input logic clr);
    @(negedge clk);
    wr_req = w; wr_data = wd; rd_req = r; rd_frame = rf; rd_coef = rc; clear = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeFrame(input int frame);
    for (int k = 0; k < 26; k++) begin
      applyStimulus(1'b1, 16'(16'h0100 + k), 1'b0, 8'd0, 5'd0, 1'b0);
      checkOutput("wr_ack", 32'(wr_ack), 32'd1);
      checkOutput("wr_addr", 32'(cep_addr), 32'(frame * 26 + k));
      tick();
    end
    checkOutput("frame_done", 32'(frame_done), 32'd1);
    checkOutput("frame_count", 32'(frame_count), 32'(frame + 1));
  endtask

  task automatic readCheck(input logic [7:0] rf, input logic [4:0] rc, input logic [12:0] exp_addr,
                           input logic [15:0] exp_data, input logic exp_err);
    applyStimulus(1'b0, 16'd0, 1'b1, rf, rc, 1'b0);
    checkOutput("rd_ack", 32'(rd_ack), 32'd1);
    checkOutput("rd_addr", 32'(cep_addr), 32'(exp_addr));
    checkOutput("rd_wren", 32'(cep_wren), 32'd0);
    tick();
    checkOutput("rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd_data", 32'(rd_data), 32'(exp_data));
    checkOutput("rd_err", 32'(rd_err), 32'(exp_err));
  endtask

  initial begin
    logic exp_w;
    for (int i = 0; i < 8192; i++) mem[i] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    wr_req = 1'b1; rd_req = 1'b1; #1;
    checkOutput("rst_wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("rst_rd_ack", 32'(rd_ack), 32'd0);
    checkOutput("rst_wren", 32'(cep_wren), 32'd0);
    @(negedge clk);
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;

    // Two full frames
    writeFrame(0);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 5'd0, 1'b0);
    checkOutput("idle_addr", 32'(cep_addr), 32'd0);
    tick();
    checkOutput("frame_done_drop", 32'(frame_done), 32'd0);
    writeFrame(1);

    readCheck(8'd1, 5'd3, 13'd29, 16'h0103, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'd0, 5'd0, 1'b0);
    tick();
    checkOutput("rd_valid_pulse", 32'(rd_valid), 32'd0);

    // Out-of-range reads
    readCheck(8'd5, 5'd3, 13'd0, 16'd0, 1'b1);
    readCheck(8'd0, 5'd26, 13'd0, 16'd0, 1'b1);
    readCheck(8'd2, 5'd0, 13'd0, 16'd0, 1'b1);

    // Contention: W,W,W,W,R repeating; writes land in frame 2
    for (int c = 0; c < 10; c++) begin
      exp_w = (c % 5) != 4;
      applyStimulus(1'b1, 16'(16'h0300 + c), 1'b1, 8'd0, 5'd0, 1'b0);
      checkOutput("arb_wr_ack", 32'(wr_ack), 32'(exp_w));
      checkOutput("arb_rd_ack", 32'(rd_ack), 32'(!exp_w));
      tick();
      if (!exp_w) checkOutput("arb_rd_data", 32'(rd_data), 32'h0100);
    end
    for (int c = 8; c < 10; c++) begin
      applyStimulus(1'b1, 16'h0400, 1'b0, 8'd0, 5'd0, 1'b0);
      checkOutput("pre_clear_addr", 32'(cep_addr), 32'(52 + c));
      tick();
    end

    // Clear with a write pending at coef_idx 10
    applyStimulus(1'b1, 16'h0500, 1'b0, 8'd0, 5'd0, 1'b1);
    checkOutput("clear_wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("clear_wren", 32'(cep_wren), 32'd0);
    tick();
    checkOutput("clear_frame_count", 32'(frame_count), 32'd0);
    applyStimulus(1'b1, 16'h0600, 1'b0, 8'd0, 5'd0, 1'b0);
    checkOutput("post_clear_ack", 32'(wr_ack), 32'd1);
    checkOutput("post_clear_addr", 32'(cep_addr), 32'd0);
    tick();

    // Reset lands while a read is being granted
    applyStimulus(1'b0, 16'd0, 1'b1, 8'd0, 5'd0, 1'b0);
    checkOutput("mid_rd_ack", 32'(rd_ack), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_rd_ack", 32'(rd_ack), 32'd0);
    tick();
    @(negedge clk);
    reset = 1'b0; rd_req = 1'b0;
    tick();
    checkOutput("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("post_rst_rd_valid2", 32'(rd_valid), 32'd0);

    // Fill the whole store
    for (int i = 0; i < 256 * 26; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 8'd0, 5'd0, 1'b0);
      checkOutput("fill_addr", 32'(cep_addr), 32'(i));
      tick();
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_frame_count", 32'(frame_count), 32'd256);
    checkOutput("fill_frame_done", 32'(frame_done), 32'd1);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 8'd0, 5'd0, 1'b0);
    checkOutput("full_wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("full_wren", 32'(cep_wren), 32'd0);
    tick();
    checkOutput("full_frame_count", 32'(frame_count), 32'd256);
    readCheck(8'd255, 5'd25, 13'd6655, 16'd6655, 1'b0);
    readCheck(8'd100, 5'd7, 13'd2607, 16'd2607, 1'b0);
    readCheck(8'd0, 5'd1, 13'd1, 16'd1, 1'b0);
    checkOutput("full_hold", 32'(full), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
